// File: rtl/packet_consumer.sv
`default_nettype none
// ============================================================================
// Module   : packet_consumer
// Brief    : Terminating sink for a packet-size / packet-body AXI-Stream pair.
//            Measures body length from tkeep, checks it against the announced
//            size, and keeps packet/byte/error statistics.
// Revision : 1.0 - initial release
// ============================================================================
module packet_consumer #(
    parameter int DW    = 512,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [DW-1:0]     axis_packetbody_tdata,
    input  logic [DW/8-1:0]   axis_packetbody_tkeep,
    input  logic              axis_packetbody_tlast,
    input  logic              axis_packetbody_tvalid,
    output logic              axis_packetbody_tready,

    input  logic [DW-1:0]     axis_packetsize_tdata,
    input  logic [DW/8-1:0]   axis_packetsize_tkeep,
    input  logic              axis_packetsize_tlast,
    input  logic              axis_packetsize_tvalid,
    output logic              axis_packetsize_tready,

    input  logic [7:0]        throttle_mask,
    input  logic              clear,

    output logic              pkt_done,
    output logic [16:0]       last_len,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  byte_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_len,
    output logic              err_keep
);

    localparam int c_KW = DW / 8;

    typedef enum logic [0:0] {
        c_ST_IDLE = 1'b0,
        c_ST_BODY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_phase;
    logic [15:0]        r_exp_len;
    logic [16:0]        r_run_len;
    logic               r_pkt_err_keep;

    logic               r_pkt_done;
    logic [16:0]        r_last_len;
    logic [CNT_W-1:0]   r_pkt_count;
    logic [CNT_W-1:0]   r_byte_count;
    logic [CNT_W-1:0]   r_err_count;
    logic               r_err_len;
    logic               r_err_keep;

    logic               w_size_ready;
    logic               w_body_ready;
    logic               w_size_hs;
    logic               w_body_hs;
    logic               w_complete;
    logic [15:0]        w_size_len;
    logic [16:0]        w_pop;
    logic [17:0]        w_sum;
    logic [16:0]        w_final_len;
    logic               w_keep_full;
    logic               w_keep_contig;
    logic               w_keep_bad;
    logic               w_mismatch;
    logic               w_pkt_keep_err;
    logic [c_KW-1:0]    w_keep_p1;
    logic               w_unused;

    assign w_unused   = ^{axis_packetbody_tdata, axis_packetsize_tdata,
                          axis_packetsize_tkeep, axis_packetsize_tlast};
    assign w_size_len = 16'(axis_packetsize_tdata);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_size_ready = 1'b0;
        w_body_ready = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_size_ready = 1'b1;
                if (w_size_hs) begin
                    w_state_nxt = c_ST_BODY;
                end
            end
            c_ST_BODY: begin
                w_body_ready = throttle_mask[r_phase];
                if (w_body_hs && axis_packetbody_tlast) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Readies are forced low while rst is held, independent of the stored state.
    assign axis_packetsize_tready = w_size_ready & ~rst;
    assign axis_packetbody_tready = w_body_ready & ~rst;

    assign w_size_hs  = axis_packetsize_tvalid & axis_packetsize_tready;
    assign w_body_hs  = axis_packetbody_tvalid & axis_packetbody_tready;
    assign w_complete = w_body_hs & axis_packetbody_tlast;

    // ------------------------------------------------------------------
    // Beat measurement and keep legality
    // ------------------------------------------------------------------
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < c_KW; i++) begin
            w_pop = w_pop + 17'(axis_packetbody_tkeep[i]);
        end
    end

    assign w_sum       = {1'b0, r_run_len} + {1'b0, w_pop};
    assign w_final_len = w_sum[17] ? 17'h1FFFF : w_sum[16:0];

    // 2^n-1 patterns are exactly those where keep & (keep+1) has no bits set.
    assign w_keep_p1     = axis_packetbody_tkeep + c_KW'(1);
    assign w_keep_full   = &axis_packetbody_tkeep;
    assign w_keep_contig = (|axis_packetbody_tkeep) &&
                           ((axis_packetbody_tkeep & w_keep_p1) == '0);
    assign w_keep_bad    = axis_packetbody_tlast ? ~w_keep_contig : ~w_keep_full;

    assign w_mismatch     = (w_final_len != {1'b0, r_exp_len});
    assign w_pkt_keep_err = r_pkt_err_keep | w_keep_bad;

    // ------------------------------------------------------------------
    // Per-packet tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase        <= 3'd0;
            r_exp_len      <= 16'd0;
            r_run_len      <= 17'd0;
            r_pkt_err_keep <= 1'b0;
        end else begin
            r_phase <= r_phase + 3'd1;
            if (w_size_hs) begin
                r_exp_len      <= w_size_len;
                r_run_len      <= 17'd0;
                r_pkt_err_keep <= 1'b0;
            end else if (w_body_hs) begin
                r_run_len <= w_final_len;
                if (w_keep_bad) begin
                    r_pkt_err_keep <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_done   <= 1'b0;
            r_last_len   <= 17'd0;
            r_pkt_count  <= '0;
            r_byte_count <= '0;
            r_err_count  <= '0;
            r_err_len    <= 1'b0;
            r_err_keep   <= 1'b0;
        end else begin
            r_pkt_done <= w_complete;
            // A same-cycle clear wins: the completing packet is dropped from stats.
            if (clear) begin
                r_last_len   <= 17'd0;
                r_pkt_count  <= '0;
                r_byte_count <= '0;
                r_err_count  <= '0;
                r_err_len    <= 1'b0;
                r_err_keep   <= 1'b0;
            end else if (w_complete) begin
                r_last_len   <= w_final_len;
                r_pkt_count  <= r_pkt_count + CNT_W'(1);
                r_byte_count <= r_byte_count + CNT_W'(w_final_len);
                if (w_mismatch || w_pkt_keep_err) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
                if (w_mismatch) begin
                    r_err_len <= 1'b1;
                end
                if (w_pkt_keep_err) begin
                    r_err_keep <= 1'b1;
                end
            end
        end
    end

    assign pkt_done   = r_pkt_done;
    assign last_len   = r_last_len;
    assign pkt_count  = r_pkt_count;
    assign byte_count = r_byte_count;
    assign err_count  = r_err_count;
    assign err_len    = r_err_len;
    assign err_keep   = r_err_keep;

endmodule
`default_nettype wire

// File: tb/tb_packet_consumer.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_consumer
// Brief    : Scoreboard bench for packet_consumer with a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_consumer;

    localparam int DW    = 512;
    localparam int KW    = DW / 8;
    localparam int CNT_W = 32;

    typedef logic [KW-1:0] keep_t;

    typedef struct {
        int  len;
        int  pkt;
        int  bytes;
        int  errs;
        bit  flen;
        bit  fkeep;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [DW-1:0]     body_tdata;
    keep_t             body_tkeep;
    logic              body_tlast;
    logic              body_tvalid;
    logic              body_tready;
    logic [DW-1:0]     size_tdata;
    keep_t             size_tkeep;
    logic              size_tlast;
    logic              size_tvalid;
    logic              size_tready;
    logic [7:0]        throttle_mask;
    logic              clear;
    logic              pkt_done;
    logic [16:0]       last_len;
    logic [CNT_W-1:0]  pkt_count;
    logic [CNT_W-1:0]  byte_count;
    logic [CNT_W-1:0]  err_count;
    logic              err_len;
    logic              err_keep;

    packet_consumer #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .axis_packetbody_tdata  (body_tdata),
        .axis_packetbody_tkeep  (body_tkeep),
        .axis_packetbody_tlast  (body_tlast),
        .axis_packetbody_tvalid (body_tvalid),
        .axis_packetbody_tready (body_tready),
        .axis_packetsize_tdata  (size_tdata),
        .axis_packetsize_tkeep  (size_tkeep),
        .axis_packetsize_tlast  (size_tlast),
        .axis_packetsize_tvalid (size_tvalid),
        .axis_packetsize_tready (size_tready),
        .throttle_mask          (throttle_mask),
        .clear                  (clear),
        .pkt_done               (pkt_done),
        .last_len               (last_len),
        .pkt_count              (pkt_count),
        .byte_count             (byte_count),
        .err_count              (err_count),
        .err_len                (err_len),
        .err_keep               (err_keep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    logic [2:0] tb_phase = 3'd0;

    // Packet-level model state
    int    m_pkt, m_bytes, m_errs;
    bit    m_flen, m_fkeep;
    exp_t  sb_q[$];
    keep_t beats[$];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        tb_phase <= rst ? 3'd0 : tb_phase + 3'd1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit last_keep_ok(input keep_t k);
        keep_t m;
        for (int n = 1; n <= KW; n++) begin
            m = '1;
            m = m >> (KW - n);
            if (k == m) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic keep_t rand_keep();
        keep_t k;
        for (int i = 0; i < KW; i += 32) k[i +: 32] = $urandom;
        return k;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW; i += 32) d[i +: 32] = $urandom;
        return d;
    endfunction

    function automatic void model_reset();
        m_pkt = 0; m_bytes = 0; m_errs = 0; m_flen = 0; m_fkeep = 0;
    endfunction

    // Ready must follow the throttle pattern at the bench's own phase count.
    always @(negedge clk) begin
        if (body_tready === 1'b1) chk("throttle_phase", throttle_mask[tb_phase], 1);
    end

    // Monitor: every completion pulse is matched against the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (pkt_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pkt_done", pkt_done, 0);
            end else begin
                e = sb_q.pop_front();
                chk("last_len",   last_len,   e.len);
                chk("pkt_count",  pkt_count,  e.pkt);
                chk("byte_count", byte_count, e.bytes);
                chk("err_count",  err_count,  e.errs);
                chk("err_len",    err_len,    e.flen);
                chk("err_keep",   err_keep,   e.fkeep);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_size(input int size);
        bit hs, done;
        done = 0;
        size_tvalid = 1'b1;
        size_tdata  = rand_data();
        size_tdata[15:0] = size[15:0];
        size_tkeep  = rand_keep();
        size_tlast  = 1'($urandom);
        // Junk body traffic while idle must be ignored.
        body_tvalid = 1'($urandom);
        body_tkeep  = rand_keep();
        body_tlast  = 1'($urandom);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            hs = size_tready;
            tick();
            if (hs) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("size_handshake_timeout", done, 1);
        size_tvalid = 1'b0;
        body_tvalid = 1'b0;
    endtask

    task automatic send_body(input int size, input bit gaps, input bit clr_last,
                             output int first_hs, output int last_hs);
        int   len, n;
        bit   kerr, mism, hs, done;
        exp_t e;
        n = beats.size();
        len = 0;
        kerr = 0;
        for (int i = 0; i < n; i++) begin
            len += $countones(beats[i]);
            if (i < n - 1) begin
                if (beats[i] != '1) kerr = 1;
            end else if (!last_keep_ok(beats[i])) begin
                kerr = 1;
            end
        end
        if (len > 131071) len = 131071;
        mism = (len != (size & 16'hFFFF));
        first_hs = -1;
        last_hs  = -1;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    body_tvalid = 1'b0;
                    size_tvalid = 1'($urandom);
                    tick();
                end
            end
            body_tvalid = 1'b1;
            body_tkeep  = beats[i];
            body_tlast  = (i == n - 1);
            body_tdata  = rand_data();
            size_tvalid = 1'($urandom);
            size_tdata  = rand_data();
            clear       = clr_last && (i == n - 1);
            done = 0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                hs = body_tready;
                tick();
                if (hs) begin
                    done = 1;
                    break;
                end
            end
            if (!done) chk("body_handshake_timeout", done, 1);
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
        end
        clear       = 1'b0;
        body_tvalid = 1'b0;
        size_tvalid = 1'b0;
        if (clr_last) begin
            model_reset();
            e.len = 0;
        end else begin
            m_pkt++;
            m_bytes += len;
            if (mism || kerr) m_errs++;
            m_flen  |= mism;
            m_fkeep |= kerr;
            e.len = len;
        end
        e.pkt = m_pkt; e.bytes = m_bytes; e.errs = m_errs;
        e.flen = m_flen; e.fkeep = m_fkeep;
        sb_q.push_back(e);
    endtask

    task automatic packet(input int size, input bit gaps);
        int f, l;
        send_size(size);
        send_body(size, gaps, 1'b0, f, l);
    endtask

    initial begin
        int f, l, got, nb, sz, len;
        bit hs;

        rst = 1'b1; clear = 1'b0; throttle_mask = 8'hFF;
        body_tdata = '0; body_tkeep = '0; body_tlast = 1'b0; body_tvalid = 1'b0;
        size_tdata = '0; size_tkeep = '0; size_tlast = 1'b0; size_tvalid = 1'b0;
        model_reset();

        // Reset with random traffic on both streams
        for (int c = 0; c < 3; c++) begin
            body_tvalid = 1'($urandom); size_tvalid = 1'($urandom);
            size_tdata = rand_data(); body_tkeep = rand_keep();
            @(negedge clk);
            chk("rst_size_ready", size_tready, 0);
            chk("rst_body_ready", body_tready, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_last_len", last_len, 0);
        chk("rst_counts", pkt_count | byte_count | err_count, 0);
        chk("rst_flags", {err_len, err_keep}, 0);
        @(posedge clk); #1;
        rst = 1'b0; body_tvalid = 1'b0; size_tvalid = 1'b0;
        @(negedge clk);
        chk("size_ready_after_rst", size_tready, 1);
        tick();

        // Good packet: 64 + 64 + 2 = 130
        beats = {keep_t'('1), keep_t'('1), keep_t'(64'h3)};
        packet(130, 0);
        // Length mismatch, then a good packet leaves err_count untouched
        beats = {keep_t'('1), keep_t'('1)};
        packet(100, 0);
        beats = {keep_t'('1)};
        packet(64, 1);
        // Keep violations: middle beat, then last beat
        beats = {keep_t'('1), keep_t'(64'hFF), keep_t'('1)};
        packet(136, 0);
        beats = {keep_t'('1), keep_t'(64'h5)};
        packet(66, 0);
        // Size zero always mismatches
        beats = {keep_t'(64'h1)};
        packet(0, 0);

        // Throttle: ready on even phases only
        throttle_mask = 8'h55;
        beats.delete();
        for (int i = 0; i < 10; i++) beats.push_back('1);
        send_size(640);
        send_body(640, 0, 0, f, l);
        chk("throttle_span_cycles", l - f, 18);
        throttle_mask = 8'hFF;
        tick();

        // Clear coinciding with the completing handshake
        beats = {keep_t'('1)};
        send_size(64);
        send_body(64, 0, 1, f, l);
        tick();
        // Clear during the pkt_done cycle
        beats = {keep_t'('1), keep_t'(64'h7)};
        send_size(67);
        send_body(67, 0, 0, f, l);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
        chk("clear_pkt_count", pkt_count, 0);
        chk("clear_byte_count", byte_count, 0);
        chk("clear_err_count", err_count, 0);
        chk("clear_last_len", last_len, 0);
        tick();

        // Reset mid-packet: partial packet discarded, remaining beats refused
        send_size(256);
        body_tvalid = 1'b1; body_tkeep = '1; body_tlast = 1'b0;
        got = 0;
        for (int c = 0; c < 100 && got < 2; c++) begin
            @(negedge clk);
            hs = body_tready;
            tick();
            if (hs) got++;
        end
        chk("partial_beats", got, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_body_ready", body_tready, 0);
            tick();
        end
        body_tvalid = 1'b0;
        beats = {keep_t'('1)};
        packet(64, 0);
        tick();

        // Randomized packets
        for (int p = 0; p < 40; p++) begin
            throttle_mask = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(1, 255));
            nb = $urandom_range(1, 6);
            beats.delete();
            len = 0;
            for (int i = 0; i < nb; i++) begin
                keep_t k;
                if (i < nb - 1) begin
                    k = ($urandom_range(0, 99) < 85) ? keep_t'('1) : rand_keep();
                end else if ($urandom_range(0, 99) < 80) begin
                    k = '1;
                    k = k >> (KW - $urandom_range(1, KW));
                end else begin
                    k = rand_keep();
                end
                beats.push_back(k);
                len += $countones(k);
            end
            case ($urandom_range(0, 9))
                0:       sz = 0;
                1, 2:    sz = $urandom_range(0, 500);
                default: sz = len;
            endcase
            packet(sz, 1'($urandom));
        end

        repeat (4) tick();
        chk("scoreboard_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
